// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the data-memory bus controller:
// FSM states, address-region decode and MMIO register offsets.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      REG_RAM  = 2'd0,
      REG_MMIO = 2'd1,
      REG_ERR  = 2'd2
   } region_t;

   localparam logic [3:0] CYCLE_OFS  = 4'h0;
   localparam logic [3:0] TOHOST_OFS = 4'h4;

   function automatic logic [31:0] byte_merge(
      input logic [31:0] old_val,
      input logic [31:0] new_val,
      input logic [3:0]  be
   );
      logic [31:0] lane_mask;
      lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old_val & ~lane_mask) | (new_val & lane_mask);
   endfunction

   // Only +0x0 and +0x4 of the 16-byte MMIO window are backed by registers.
   function automatic region_t decode_region(
      input logic [31:0] addr,
      input logic [31:0] ram_base,
      input logic [31:0] ram_mask,
      input logic [31:0] mmio_base
   );
      region_t region;
      if ((addr & ~ram_mask) == ram_base) begin
         region = REG_RAM;
      end else if (((addr & ~32'h0000_000F) == mmio_base) && !addr[3]) begin
         region = REG_MMIO;
      end else begin
         region = REG_ERR;
      end
      return region;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request/response bus of the data-memory controller.
// The CPU drives the master modport, the controller uses the slave modport.
interface mem_bus_ctrl_if;
   logic        req_i;
   logic [3:0]  we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        ready_o;
   logic        err_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  rdata_o, ready_o, err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output rdata_o, ready_o, err_o
   );
endinterface

// File: rtl/mmio_regs.sv
// MMIO register block: free-running cycle counter, byte-writable tohost
// register and the sticky done flag raised by a nonzero tohost value.
module mmio_regs
   import mem_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_sel,
   input  logic        i_we,
   input  logic [3:0]  i_ofs,
   input  logic [3:0]  i_be,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_done
);

   logic [31:0] r_cycle;
   logic [31:0] r_tohost;
   logic        r_done;
   logic        w_tohost_wr;
   logic [31:0] w_tohost_next;

   assign w_tohost_wr   = i_sel && i_we && (i_ofs == TOHOST_OFS);
   assign w_tohost_next = byte_merge(r_tohost, i_wdata, i_be);
   assign o_done        = r_done;

   // Cycle counter, wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle <= 32'd0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
      end
   end

   // tohost update; done is judged on the merged value, never cleared by writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tohost <= 32'd0;
         r_done   <= 1'b0;
      end else if (w_tohost_wr) begin
         r_tohost <= w_tohost_next;
         if (w_tohost_next != 32'd0) begin
            r_done <= 1'b1;
         end
      end
   end

   // Read mux.
   always_comb begin
      o_rdata = 32'd0;
      case (i_ofs)
         CYCLE_OFS:  o_rdata = r_cycle;
         TOHOST_OFS: o_rdata = r_tohost;
         default:    o_rdata = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller: req/ready handshake between CPU and BRAM with
// 1- or 2-cycle read latency, RAM/MMIO/fault decode and MMIO registers.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int          ADDR_WIDTH   = 10,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] RAM_BASE     = 32'h0000_0000,
   parameter logic [31:0] MMIO_BASE    = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_bus_ctrl_if.slave         bus,
   output logic                  done_o,
   output logic                  mem_en_o,
   output logic [3:0]            mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_din_o,
   input  logic [31:0]           mem_dout_i
);

   localparam logic [31:0] RAM_MASK = (32'd1 << (ADDR_WIDTH + 2)) - 32'd1;

   if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
      $error("mem_bus_ctrl: READ_LATENCY must be 1 or 2");
   end
   if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > 29)) begin : g_bad_width
      $error("mem_bus_ctrl: ADDR_WIDTH must be in 1..29");
   end

   state_t                r_state;
   state_t                w_next_state;
   region_t               w_region;
   region_t               r_region;
   logic                  r_is_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_rdata;
   logic [31:0]           w_mmio_rdata;
   logic [3:0]            w_mmio_ofs;
   logic                  w_accept;
   logic                  w_is_write;
   logic                  w_mmio_sel;
   logic                  w_mmio_we;
   logic [31:0]           w_rdata;
   logic                  w_ready;
   logic                  w_err;

   assign w_region   = decode_region(bus.addr_i, RAM_BASE, RAM_MASK, MMIO_BASE);
   assign w_mmio_ofs = {bus.addr_i[3:2], 2'b00};
   assign w_is_write = (bus.we_i != 4'h0);
   // Reset wins over a simultaneous request.
   assign w_accept   = (r_state == IDLE) && bus.req_i && !reset;

   assign bus.rdata_o = w_rdata;
   assign bus.ready_o = w_ready;
   assign bus.err_o   = w_err;

   mmio_regs u_mmio (
      .clk     (clk),
      .reset   (reset),
      .i_sel   (w_mmio_sel),
      .i_we    (w_mmio_we),
      .i_ofs   (w_mmio_ofs),
      .i_be    (bus.we_i),
      .i_wdata (bus.wdata_i),
      .o_rdata (w_mmio_rdata),
      .o_done  (done_o)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Access context captured at acceptance; MMIO read data is snapshotted here.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr     <= '0;
         r_region   <= REG_RAM;
         r_is_write <= 1'b0;
         r_rdata    <= 32'd0;
      end else if (w_accept) begin
         r_addr     <= bus.addr_i[ADDR_WIDTH+1:2];
         r_region   <= w_region;
         r_is_write <= w_is_write;
         r_rdata    <= ((w_region == REG_MMIO) && !w_is_write) ? w_mmio_rdata : 32'd0;
      end
   end

   // Next state, BRAM steering and response generation.
   always_comb begin
      w_next_state = r_state;
      mem_en_o     = 1'b0;
      mem_we_o     = 4'h0;
      mem_addr_o   = r_addr;
      mem_din_o    = 32'd0;
      w_mmio_sel   = 1'b0;
      w_mmio_we    = 1'b0;
      w_ready      = 1'b0;
      w_err        = 1'b0;
      w_rdata      = 32'd0;
      case (r_state)
         IDLE: begin
            mem_addr_o = bus.addr_i[ADDR_WIDTH+1:2];
            if (w_accept) begin
               case (w_region)
                  REG_RAM: begin
                     mem_en_o     = 1'b1;
                     mem_we_o     = bus.we_i;
                     mem_din_o    = bus.wdata_i;
                     w_next_state = (!w_is_write && (READ_LATENCY == 2)) ? WAIT : RESP;
                  end
                  REG_MMIO: begin
                     w_mmio_sel   = 1'b1;
                     w_mmio_we    = w_is_write;
                     w_next_state = RESP;
                  end
                  default: begin
                     w_next_state = RESP;
                  end
               endcase
            end else begin
               w_next_state = IDLE;
            end
         end
         WAIT: begin
            w_next_state = RESP;
         end
         RESP: begin
            w_ready      = 1'b1;
            w_err        = (r_region == REG_ERR);
            w_next_state = IDLE;
            if (r_is_write) begin
               w_rdata = 32'd0;
            end else if (r_region == REG_RAM) begin
               w_rdata = mem_dout_i;
            end else if (r_region == REG_MMIO) begin
               w_rdata = r_rdata;
            end else begin
               w_rdata = 32'd0;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed testbench for mem_bus_ctrl: one instance with 1-cycle and one with
// 2-cycle BRAM read latency, each backed by a small behavioural BRAM.
module tb_mem_bus_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1, rst2;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   tb_cyc  = 0;

   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   mem_bus_ctrl_if bus1();
   mem_bus_ctrl_if bus2();

   logic        done1, en1, done2, en2;
   logic [3:0]  mwe1, mwe2;
   logic [9:0]  maddr1, maddr2;
   logic [31:0] din1, dout1, din2, dout2, stage2;
   logic [31:0] mem1 [0:1023];
   logic [31:0] mem2 [0:1023];

   mem_bus_ctrl #(.ADDR_WIDTH(10), .READ_LATENCY(1), .RAM_BASE(32'h0), .MMIO_BASE(32'h8000_0000)) dut1 (
      .clk(clk), .reset(rst1), .bus(bus1), .done_o(done1), .mem_en_o(en1), .mem_we_o(mwe1),
      .mem_addr_o(maddr1), .mem_din_o(din1), .mem_dout_i(dout1));

   mem_bus_ctrl #(.ADDR_WIDTH(10), .READ_LATENCY(2), .RAM_BASE(32'h0), .MMIO_BASE(32'h8000_0000)) dut2 (
      .clk(clk), .reset(rst2), .bus(bus2), .done_o(done2), .mem_en_o(en2), .mem_we_o(mwe2),
      .mem_addr_o(maddr2), .mem_din_o(din2), .mem_dout_i(dout2));

   // Behavioural BRAMs: latency 1 = registered read, latency 2 = extra output register.
   always @(posedge clk) begin
      if (en1) begin
         for (int b = 0; b < 4; b++) if (mwe1[b]) mem1[maddr1][8*b +: 8] <= din1[8*b +: 8];
         dout1 <= mem1[maddr1];
      end
   end

   always @(posedge clk) begin
      if (en2) begin
         for (int b = 0; b < 4; b++) if (mwe2[b]) mem2[maddr2][8*b +: 8] <= din2[8*b +: 8];
         stage2 <= mem2[maddr2];
      end
      dout2 <= stage2;
   end

   task automatic bus_op1(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic en_acc, output logic [3:0] we_acc, output int acc_cyc);
      @(negedge clk);
      bus1.req_i = 1'b1; bus1.we_i = we; bus1.addr_i = addr; bus1.wdata_i = wdata;
      #1;
      en_acc = en1; we_acc = mwe1; acc_cyc = tb_cyc;
      lat = 0; rdata = 32'hX; err = 1'bX;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); @(negedge clk);
         if (bus1.ready_o) begin lat = i; rdata = bus1.rdata_o; err = bus1.err_o; break; end
      end
      bus1.req_i = 1'b0; bus1.we_i = 4'h0;
      n_tests++;
      if (lat == 0) begin n_fail++; $display("FAIL bus1_timeout addr=%h: no ready_o within 8 cycles", addr); end
   endtask

   task automatic bus_op2(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      bus2.req_i = 1'b1; bus2.we_i = we; bus2.addr_i = addr; bus2.wdata_i = wdata;
      lat = 0; rdata = 32'hX; err = 1'bX;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); @(negedge clk);
         if (bus2.ready_o) begin lat = i; rdata = bus2.rdata_o; err = bus2.err_o; break; end
      end
      bus2.req_i = 1'b0; bus2.we_i = 4'h0;
      n_tests++;
      if (lat == 0) begin n_fail++; $display("FAIL bus2_timeout addr=%h: no ready_o within 8 cycles", addr); end
   endtask

   task automatic test_reset();
      bus1.req_i = 1'b0; bus1.we_i = 4'h0; bus1.addr_i = 32'h0; bus1.wdata_i = 32'h0;
      bus2.req_i = 1'b0; bus2.we_i = 4'h0; bus2.addr_i = 32'h0; bus2.wdata_i = 32'h0;
      rst1 = 1'b1; rst2 = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++; if ({bus1.ready_o, bus1.err_o, done1, en1} !== 4'b0000) begin n_fail++;
         $display("FAIL reset_flags: got ready/err/done/en=%b expected 0000", {bus1.ready_o, bus1.err_o, done1, en1}); end
      n_tests++; if (mwe1 !== 4'h0) begin n_fail++; $display("FAIL reset_mem_we: got %h expected 0", mwe1); end
      n_tests++; if (bus1.rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus1.rdata_o); end
      // A request presented while reset is high must not be accepted.
      bus1.req_i = 1'b1; bus1.addr_i = 32'h10;
      #1;
      n_tests++; if (en1 !== 1'b0) begin n_fail++; $display("FAIL reset_priority_en: got %b expected 0", en1); end
      repeat (2) @(negedge clk);
      n_tests++; if (bus1.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_priority_ready: got %b expected 0", bus1.ready_o); end
      bus1.req_i = 1'b0;
      rst1 = 1'b0; rst2 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ram_rw();
      logic [31:0] rd; logic er, en; logic [3:0] wa; int lat, ac;
      bus_op1(4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat, en, wa, ac);
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL ram_wr_latency: got %0d expected 1", lat); end
      n_tests++; if ({en, wa, er} !== 6'b1_1111_0) begin n_fail++; $display("FAIL ram_wr_steer: got en/we/err=%b expected 1_1111_0", {en, wa, er}); end
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ram_wr_rdata: got %h expected 0", rd); end
      n_tests++; if (mem1[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_wr_stored: got %h expected deadbeef", mem1[4]); end
      bus_op1(4'h0, 32'h10, 32'h0, rd, er, lat, en, wa, ac);
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL ram_rd_latency: got %0d expected 1", lat); end
      n_tests++; if ({en, wa} !== 5'b1_0000) begin n_fail++; $display("FAIL ram_rd_steer: got en/we=%b expected 1_0000", {en, wa}); end
      n_tests++; if ({rd, er} !== {32'hDEADBEEF, 1'b0}) begin n_fail++; $display("FAIL ram_rd_data: got %h err=%b expected deadbeef err=0", rd, er); end
      // Last RAM word.
      bus_op1(4'hF, 32'h0000_0FFC, 32'hCAFEF00D, rd, er, lat, en, wa, ac);
      bus_op1(4'h0, 32'h0000_0FFC, 32'h0, rd, er, lat, en, wa, ac);
      n_tests++; if ({rd, er} !== {32'hCAFEF00D, 1'b0}) begin n_fail++; $display("FAIL ram_top_word: got %h err=%b expected cafef00d err=0", rd, er); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd; logic er, en; logic [3:0] wa; int lat, ac;
      bus_op1(4'hF, 32'h20, 32'h11223344, rd, er, lat, en, wa, ac);
      bus_op1(4'h1, 32'h20, 32'h000000AA, rd, er, lat, en, wa, ac);
      bus_op1(4'h2, 32'h20, 32'h0000BB00, rd, er, lat, en, wa, ac);
      bus_op1(4'h0, 32'h20, 32'h0, rd, er, lat, en, wa, ac);
      n_tests++; if (rd !== 32'h1122BBAA) begin n_fail++; $display("FAIL ram_lanes: got %h expected 1122bbaa", rd); end
      n_tests++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL done_before: got %b expected 0", done1); end
      bus_op1(4'hF, 32'h8000_0004, 32'h11223344, rd, er, lat, en, wa, ac);
      n_tests++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL done_after: got %b expected 1", done1); end
      n_tests++; if ({en, lat} !== {1'b0, 32'd1}) begin n_fail++; $display("FAIL mmio_wr: got en=%b lat=%0d expected en=0 lat=1", en, lat); end
      bus_op1(4'h1, 32'h8000_0004, 32'h000000AA, rd, er, lat, en, wa, ac);
      bus_op1(4'h2, 32'h8000_0004, 32'h0000BB00, rd, er, lat, en, wa, ac);
      bus_op1(4'h0, 32'h8000_0004, 32'h0, rd, er, lat, en, wa, ac);
      n_tests++; if ({rd, er} !== {32'h1122BBAA, 1'b0}) begin n_fail++; $display("FAIL tohost_lanes: got %h err=%b expected 1122bbaa err=0", rd, er); end
   endtask

   task automatic test_faults();
      logic [31:0] rd; logic er, en; logic [3:0] wa; int lat, ac;
      bus_op1(4'h0, 32'h4000_0000, 32'h0, rd, er, lat, en, wa, ac);
      n_tests++; if ({lat, er, rd, en} !== {32'd1, 1'b1, 32'h0, 1'b0}) begin n_fail++;
         $display("FAIL fault_rd: got lat=%0d err=%b rdata=%h en=%b expected 1 1 0 0", lat, er, rd, en); end
      bus_op1(4'hF, 32'h8000_0008, 32'h55, rd, er, lat, en, wa, ac);
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL fault_mmio8: got err=%b expected 1", er); end
      bus_op1(4'h0, 32'h8000_000C, 32'h0, rd, er, lat, en, wa, ac);
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL fault_mmioC: got err=%b expected 1", er); end
      bus_op1(4'h0, 32'h8000_0004, 32'h0, rd, er, lat, en, wa, ac);
      n_tests++; if ({rd, er} !== {32'h1122BBAA, 1'b0}) begin n_fail++; $display("FAIL fault_tohost_kept: got %h err=%b expected 1122bbaa err=0", rd, er); end
      bus_op1(4'h0, 32'h0000_1000, 32'h0, rd, er, lat, en, wa, ac);
      n_tests++; if ({er, en} !== 2'b10) begin n_fail++; $display("FAIL fault_ram_end: got err/en=%b expected 10", {er, en}); end
      // Aliases word 4 if the upper address bits were ignored.
      bus_op1(4'hF, 32'h4000_0010, 32'h12345678, rd, er, lat, en, wa, ac);
      n_tests++; if ({er, en, wa} !== 6'b1_0_0000) begin n_fail++; $display("FAIL fault_wr_steer: got err/en/we=%b expected 1_0_0000", {er, en, wa}); end
      bus_op1(4'h0, 32'h10, 32'h0, rd, er, lat, en, wa, ac);
      n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fault_no_ram_write: got %h expected deadbeef", rd); end
   endtask

   task automatic test_cycle();
      logic [31:0] va, vb, vc, rd; logic er, en; logic [3:0] wa; int lat, aa, ab, acy, ac;
      bus_op1(4'h0, 32'h8000_0000, 32'h0, va, er, lat, en, wa, aa);
      repeat (5) @(negedge clk);
      bus_op1(4'h0, 32'h8000_0000, 32'h0, vb, er, lat, en, wa, ab);
      n_tests++; if ((vb - va) !== 32'(ab - aa)) begin n_fail++; $display("FAIL cycle_delta: got %0d expected %0d", vb - va, ab - aa); end
      bus_op1(4'hF, 32'h8000_0000, 32'h0, rd, er, lat, en, wa, ac);
      n_tests++; if ({er, rd} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL cycle_wr_noerr: got err=%b rdata=%h expected 0 0", er, rd); end
      bus_op1(4'h0, 32'h8000_0000, 32'h0, vc, er, lat, en, wa, acy);
      n_tests++; if ((vc - va) !== 32'(acy - aa)) begin n_fail++; $display("FAIL cycle_wr_ignored: got %0d expected %0d", vc - va, acy - aa); end
      // Wrap: FFFF_FFFE -> FFFF_FFFF -> 0 at the acceptance cycle two edges later.
      @(negedge clk);
      dut1.u_mmio.r_cycle = 32'hFFFF_FFFE;
      @(negedge clk);
      bus_op1(4'h0, 32'h8000_0000, 32'h0, rd, er, lat, en, wa, ac);
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL cycle_wrap: got %h expected 0", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er, en; logic [3:0] wa; int lat, a1, a2;
      bus_op1(4'hF, 32'h40, 32'hA5A5_0001, rd, er, lat, en, wa, a1);
      bus_op1(4'hF, 32'h44, 32'h5A5A_0002, rd, er, lat, en, wa, a2);
      n_tests++; if ((a2 - a1) != 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 2", a2 - a1); end
      bus_op1(4'h0, 32'h40, 32'h0, rd, er, lat, en, wa, a1);
      n_tests++; if (rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL b2b_rd0: got %h expected a5a50001", rd); end
      bus_op1(4'h0, 32'h44, 32'h0, rd, er, lat, en, wa, a2);
      n_tests++; if (rd !== 32'h5A5A_0002) begin n_fail++; $display("FAIL b2b_rd1: got %h expected 5a5a0002", rd); end
   endtask

   task automatic test_latency2();
      logic [31:0] rd; logic er; int lat;
      bus_op2(4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL rl2_wr_latency: got %0d expected 1", lat); end
      @(negedge clk);
      bus2.req_i = 1'b1; bus2.we_i = 4'h0; bus2.addr_i = 32'h10;
      #1;
      n_tests++; if ({en2, maddr2} !== {1'b1, 10'd4}) begin n_fail++; $display("FAIL rl2_accept: got en=%b addr=%h expected 1 004", en2, maddr2); end
      @(negedge clk);
      n_tests++; if ({bus2.ready_o, en2, maddr2} !== {2'b00, 10'd4}) begin n_fail++;
         $display("FAIL rl2_wait: got ready=%b en=%b addr=%h expected 0 0 004", bus2.ready_o, en2, maddr2); end
      @(negedge clk);
      n_tests++; if ({bus2.ready_o, bus2.err_o, maddr2} !== {2'b10, 10'd4}) begin n_fail++;
         $display("FAIL rl2_resp: got ready=%b err=%b addr=%h expected 1 0 004", bus2.ready_o, bus2.err_o, maddr2); end
      n_tests++; if (bus2.rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rl2_rdata: got %h expected deadbeef", bus2.rdata_o); end
      bus2.req_i = 1'b0;
      bus_op2(4'h0, 32'h8000_0004, 32'h0, rd, er, lat);
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL rl2_mmio_latency: got %0d expected 1", lat); end
   endtask

   task automatic test_reset_mid_access();
      logic [31:0] rd; logic er; int lat;
      bus_op2(4'hF, 32'h8000_0004, 32'h1, rd, er, lat);
      n_tests++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL rl2_done_set: got %b expected 1", done2); end
      @(negedge clk);
      bus2.req_i = 1'b1; bus2.we_i = 4'h0; bus2.addr_i = 32'h10;
      @(negedge clk);
      rst2 = 1'b1;
      n_tests++; if (bus2.ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wait_ready: got %b expected 0", bus2.ready_o); end
      @(negedge clk);
      n_tests++; if ({bus2.ready_o, bus2.err_o, done2, en2, mwe2} !== 8'h00) begin n_fail++;
         $display("FAIL rst_mid_outputs: got ready/err/done/en/we=%b expected 0", {bus2.ready_o, bus2.err_o, done2, en2, mwe2}); end
      n_tests++; if (bus2.rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h expected 0", bus2.rdata_o); end
      bus2.req_i = 1'b0;
      @(negedge clk);
      rst2 = 1'b0;
      n_tests++; if (bus2.ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_ready: got %b expected 0", bus2.ready_o); end
      bus_op2(4'h0, 32'h10, 32'h0, rd, er, lat);
      n_tests++; if ({lat, rd, er} !== {32'd2, 32'hDEADBEEF, 1'b0}) begin n_fail++;
         $display("FAIL rst_fresh_read: got lat=%0d rdata=%h err=%b expected 2 deadbeef 0", lat, rd, er); end
      n_tests++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL rst_done_clear: got %b expected 0", done2); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ram_rw();
      test_byte_lanes();
      test_faults();
      test_cycle();
      test_back_to_back();
      test_latency2();
      test_reset_mid_access();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
